// File: rtl/mod_dec_addroundkey.sv
// ---------------------------------------------------------------------------
// mod_dec_addroundkey
//   Decryption-side AddRoundKey stage of the AES-256 core. Captures the 15
//   round keys produced by key expansion (k0 first, k14 last), then XORs them
//   in reverse order (k14 down to k0) into the states coming from the inverse
//   round datapath. A single output register gives full-throughput flow.
//
//   Optional build macro: DEC_ARK_ERR_EN adds a sticky protocol error flag.
//
// Ports
//   clk               clock
//   resetn            synchronous reset, active-high
//   key_flush         discard stored keys, return to key loading
//   key_valid/key_in  round key input (byte i = key_in[8*i +: 8])
//   key_ready         high while loading keys
//   keys_loaded       all NK keys stored
//   inp_valid_addRK / inp_addRK / inp_ready_addRK      state input handshake
//   outp_valid_addRK / outp_addRK / outp_ready_addRK   state output handshake
//   round_addRK       index of key applied to the current output
//   last_round_addRK  output is plaintext (key k0 applied)
//   err_addRK         (DEC_ARK_ERR_EN only) sticky protocol violation flag
// ---------------------------------------------------------------------------
module mod_dec_addroundkey #(
  parameter int N  = 16,
  parameter int NK = 15,
  parameter int KW = 128
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key_flush,
  input  logic               key_valid,
  input  logic [KW-1:0]      key_in,
  output logic               key_ready,
  output logic               keys_loaded,
  input  logic               inp_valid_addRK,
  input  logic [N-1:0][7:0]  inp_addRK,
  output logic               inp_ready_addRK,
  output logic               outp_valid_addRK,
  output logic [N-1:0][7:0]  outp_addRK,
  input  logic               outp_ready_addRK,
  output logic [3:0]         round_addRK,
  output logic               last_round_addRK
`ifdef DEC_ARK_ERR_EN
  ,
  output logic               err_addRK
`endif
);

  typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NK - 1);

  state_t              state_r, state_next_s;
  logic [3:0]          wr_ptr_r;
  logic [3:0]          rd_ptr_r;
  logic [KW-1:0]       key_mem_r [NK];
  logic                keys_loaded_r;
  logic                outp_valid_r;
  logic [N-1:0][7:0]   outp_data_r;
  logic [3:0]          round_r;
  logic                last_r;

  logic                key_wr_s;
  logic                inp_ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic [KW-1:0]       key_sel_s;
  logic [N-1:0][7:0]   xor_data_s;

  // Handshake decode: a single output register can take a new state whenever
  // it is empty or being drained in the same cycle.
  always_comb begin
    inp_ready_s = (state_r == RUN) && (!outp_valid_r || outp_ready_addRK);
    in_xfer_s   = inp_valid_addRK && inp_ready_s;
    out_xfer_s  = outp_valid_r && outp_ready_addRK;
  end

  // Next-state logic; keys are only written while loading.
  always_comb begin
    state_next_s = state_r;
    key_wr_s     = 1'b0;
    case (state_r)
      LOAD: begin
        key_wr_s = key_valid;
        if (key_valid && (wr_ptr_r == LAST_IDX)) begin
          state_next_s = RUN;
        end else begin
          state_next_s = LOAD;
        end
      end
      RUN: begin
        state_next_s = RUN;
      end
      default: begin
        state_next_s = LOAD;
      end
    endcase
  end

  // Round key selection and bytewise XOR with the incoming state.
  always_comb begin
    key_sel_s  = key_mem_r[rd_ptr_r];
    xor_data_s = '0;
    for (int i = 0; i < N; i++) begin
      xor_data_s[i] = inp_addRK[i] ^ key_sel_s[8*i +: 8];
    end
  end

  // State register; flush returns to key loading.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r <= LOAD;
    end else if (key_flush) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Key storage; contents are irrelevant until fully reloaded, so no reset.
  always_ff @(posedge clk) begin
    if (!key_flush && key_wr_s) begin
      key_mem_r[wr_ptr_r] <= key_in;
    end
  end

  // Write/read pointers and the keys_loaded flag.
  always_ff @(posedge clk) begin
    if (resetn || key_flush) begin
      wr_ptr_r      <= 4'd0;
      rd_ptr_r      <= LAST_IDX;
      keys_loaded_r <= 1'b0;
    end else begin
      if (key_wr_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_IDX) ? 4'd0 : (wr_ptr_r + 4'd1);
        if (wr_ptr_r == LAST_IDX) begin
          keys_loaded_r <= 1'b1;
        end
      end
      // Wrap to k14 after k0 so the next block restarts the key schedule.
      if (in_xfer_s) begin
        rd_ptr_r <= (rd_ptr_r == 4'd0) ? LAST_IDX : (rd_ptr_r - 4'd1);
      end
    end
  end

  // Output register: load on input transfer (replaces a draining result with
  // no bubble), clear on a bare output transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (resetn || key_flush) begin
      outp_valid_r <= 1'b0;
      outp_data_r  <= '0;
      round_r      <= 4'd0;
      last_r       <= 1'b0;
    end else if (in_xfer_s) begin
      outp_valid_r <= 1'b1;
      outp_data_r  <= xor_data_s;
      round_r      <= rd_ptr_r;
      last_r       <= (rd_ptr_r == 4'd0);
    end else if (out_xfer_s) begin
      outp_valid_r <= 1'b0;
      last_r       <= 1'b0;
    end
  end

`ifdef DEC_ARK_ERR_EN
  logic err_r;
  logic viol_s;

  // Protocol violation: state offered while loading, or key offered while running.
  always_comb begin
    viol_s = ((state_r == LOAD) && inp_valid_addRK) ||
             ((state_r == RUN) && key_valid);
  end

  // Sticky error flag, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (resetn || key_flush) begin
      err_r <= 1'b0;
    end else if (viol_s) begin
      err_r <= 1'b1;
    end
  end

  assign err_addRK = err_r;
`endif

  assign key_ready        = (state_r == LOAD);
  assign keys_loaded      = keys_loaded_r;
  assign inp_ready_addRK  = inp_ready_s;
  assign outp_valid_addRK = outp_valid_r;
  assign outp_addRK       = outp_data_r;
  assign round_addRK      = round_r;
  assign last_round_addRK = last_r;

endmodule

// File: tb/tb_mod_dec_addroundkey.sv
// ---------------------------------------------------------------------------
// tb_mod_dec_addroundkey
//   Directed self-checking bench for mod_dec_addroundkey: reset values, key
//   loading, reverse key order, byte mapping, backpressure, flush and reset
//   mid-block, plus the error flag when DEC_ARK_ERR_EN is defined.
// ---------------------------------------------------------------------------
module tb_mod_dec_addroundkey;

  logic              clk;
  logic              resetn;
  logic              key_flush;
  logic              key_valid;
  logic [127:0]      key_in;
  logic              key_ready;
  logic              keys_loaded;
  logic              inp_valid_addRK;
  logic [15:0][7:0]  inp_addRK;
  logic              inp_ready_addRK;
  logic              outp_valid_addRK;
  logic [15:0][7:0]  outp_addRK;
  logic              outp_ready_addRK;
  logic [3:0]        round_addRK;
  logic              last_round_addRK;
`ifdef DEC_ARK_ERR_EN
  logic              err_addRK;
`endif

  int errors = 0;
  int checks = 0;

  mod_dec_addroundkey dut (
    .clk              (clk),
    .resetn           (resetn),
    .key_flush        (key_flush),
    .key_valid        (key_valid),
    .key_in           (key_in),
    .key_ready        (key_ready),
    .keys_loaded      (keys_loaded),
    .inp_valid_addRK  (inp_valid_addRK),
    .inp_addRK        (inp_addRK),
    .inp_ready_addRK  (inp_ready_addRK),
    .outp_valid_addRK (outp_valid_addRK),
    .outp_addRK       (outp_addRK),
    .outp_ready_addRK (outp_ready_addRK),
    .round_addRK      (round_addRK),
    .last_round_addRK (last_round_addRK)
`ifdef DEC_ARK_ERR_EN
    ,
    .err_addRK        (err_addRK)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads k0..k14 with every byte = i*8'h11; byte_map puts 0x0F0E..0100 in k14.
  task automatic load_keys(input bit byte_map);
    key_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (byte_map && i == 14) key_in = 128'h0F0E0D0C0B0A09080706050403020100;
      else                     key_in = rep(8'(i * 17));
      tick();
      if (i == 13) chk("loaded_early", {127'd0, keys_loaded}, 128'd0);
    end
    key_valid = 1'b0;
    chk("keys_loaded", {127'd0, keys_loaded}, 128'd1);
    chk("key_ready_run", {127'd0, key_ready}, 128'd0);
  endtask

  initial begin
    resetn = 1'b1; key_flush = 1'b0; key_valid = 1'b0; key_in = '0;
    inp_valid_addRK = 1'b0; inp_addRK = '0; outp_ready_addRK = 1'b0;
    tick(); tick();
    resetn = 1'b0;
    chk("rst_key_ready", {127'd0, key_ready}, 128'd1);
    chk("rst_loaded", {127'd0, keys_loaded}, 128'd0);
    chk("rst_inp_ready", {127'd0, inp_ready_addRK}, 128'd0);
    chk("rst_valid", {127'd0, outp_valid_addRK}, 128'd0);
    chk("rst_data", outp_addRK, 128'd0);
    chk("rst_round", {124'd0, round_addRK}, 128'd0);
    chk("rst_last", {127'd0, last_round_addRK}, 128'd0);

    // Load and reverse-order replay, 16 back-to-back zero states.
    load_keys(1'b0);
    inp_valid_addRK = 1'b1; inp_addRK = '0; outp_ready_addRK = 1'b1;
    for (int j = 0; j < 16; j++) begin
      int k;
      k = (j < 15) ? (14 - j) : 14;
      tick();
      chk("rev_valid", {127'd0, outp_valid_addRK}, 128'd1);
      chk("rev_data", outp_addRK, rep(8'(k * 17)));
      chk("rev_round", {124'd0, round_addRK}, 128'(k));
      chk("rev_last", {127'd0, last_round_addRK}, (j == 14) ? 128'd1 : 128'd0);
    end
    inp_valid_addRK = 1'b0;
    tick();
    chk("clr_valid", {127'd0, outp_valid_addRK}, 128'd0);
    chk("clr_last", {127'd0, last_round_addRK}, 128'd0);

    // Backpressure: next key is k13.
    inp_valid_addRK = 1'b1; inp_addRK = '0; outp_ready_addRK = 1'b0;
    tick();
    chk("bp_first", outp_addRK, rep(8'hDD));
    chk("bp_round", {124'd0, round_addRK}, 128'd13);
    inp_addRK = rep(8'h01);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_inp_ready", {127'd0, inp_ready_addRK}, 128'd0);
      chk("bp_hold_data", outp_addRK, rep(8'hDD));
      chk("bp_hold_valid", {127'd0, outp_valid_addRK}, 128'd1);
    end
    outp_ready_addRK = 1'b1;
    #1;
    chk("bp_ready_back", {127'd0, inp_ready_addRK}, 128'd1);
    tick();
    chk("bp_next_data", outp_addRK, rep(8'hCD));
    chk("bp_next_round", {124'd0, round_addRK}, 128'd12);
    chk("bp_next_valid", {127'd0, outp_valid_addRK}, 128'd1);
    inp_valid_addRK = 1'b0;
    tick();
    chk("bp_drain", {127'd0, outp_valid_addRK}, 128'd0);

    // Flush after the 5th output of a fresh block.
    key_flush = 1'b1; tick(); key_flush = 1'b0;
    load_keys(1'b0);
    inp_valid_addRK = 1'b1; inp_addRK = '0;
    for (int j = 0; j < 5; j++) tick();
    chk("fl_5th", outp_addRK, rep(8'hAA));
    inp_valid_addRK = 1'b0; key_flush = 1'b1;
    tick();
    key_flush = 1'b0;
    chk("fl_valid", {127'd0, outp_valid_addRK}, 128'd0);
    chk("fl_key_ready", {127'd0, key_ready}, 128'd1);
    chk("fl_loaded", {127'd0, keys_loaded}, 128'd0);
    load_keys(1'b0);
    inp_valid_addRK = 1'b1;
    tick();
    chk("fl_k14_data", outp_addRK, rep(8'hEE));
    chk("fl_k14_round", {124'd0, round_addRK}, 128'd14);
    tick(); tick();

    // Reset mid-block.
    resetn = 1'b1;
    tick();
    resetn = 1'b0; inp_valid_addRK = 1'b0;
    chk("mr_valid", {127'd0, outp_valid_addRK}, 128'd0);
    chk("mr_data", outp_addRK, 128'd0);
    chk("mr_round", {124'd0, round_addRK}, 128'd0);
    chk("mr_last", {127'd0, last_round_addRK}, 128'd0);
    chk("mr_key_ready", {127'd0, key_ready}, 128'd1);
    chk("mr_loaded", {127'd0, keys_loaded}, 128'd0);
    chk("mr_inp_ready", {127'd0, inp_ready_addRK}, 128'd0);

    // Byte mapping with k14 = 0x0F0E..0100.
    load_keys(1'b1);
    inp_valid_addRK = 1'b1; inp_addRK = rep(8'hFF);
    tick();
    inp_valid_addRK = 1'b0;
    chk("map_data", outp_addRK, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    chk("map_round", {124'd0, round_addRK}, 128'd14);
    tick();

`ifdef DEC_ARK_ERR_EN
    chk("err_idle", {127'd0, err_addRK}, 128'd0);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("err_set", {127'd0, err_addRK}, 128'd1);
    chk("err_key_ignored", {127'd0, key_ready}, 128'd0);
    tick();
    chk("err_sticky", {127'd0, err_addRK}, 128'd1);
    key_flush = 1'b1;
    tick();
    key_flush = 1'b0;
    chk("err_flush", {127'd0, err_addRK}, 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
